// File: rtl/spi_slave_regbridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regbridge
// Description : SPI mode-0 target, oversampled in the system clock domain,
//               that turns each SPI frame into byte-wide register writes
//               or reads with address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regbridge #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sclk_i,
    input  logic              ssn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oeb_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_rd   = 2'd2;
    localparam logic [1:0] c_st_wr   = 2'd3;

    // Synchronisers and previous samples for edge detection
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ssn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ssn_prev;

    // Frame state
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_bitcnt;
    logic [6:0]        r_rx_sr;
    logic [7:0]        r_tx_sr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load_pend;

    // Registered outputs
    logic              r_miso;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_frame_err;

    // Decoded events
    logic              w_sclk;
    logic              w_ssn;
    logic              w_mosi;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_ssn_rise;
    logic              w_ssn_fall;
    logic              w_active;
    logic              w_byte_done;
    logic              w_abort;
    logic [7:0]        w_rx_next;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_rw;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ssn  = r_ssn_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ssn_rise  = w_ssn & ~r_ssn_prev;
    assign w_ssn_fall  = ~w_ssn & r_ssn_prev;

    assign w_active    = (r_state != c_st_idle);
    // A rise on the 8th bit completes the byte even if SSn rises in the same cycle
    assign w_byte_done = w_active & w_sclk_rise & (r_bitcnt == 3'd7);
    assign w_abort     = w_active & w_ssn_rise & (r_bitcnt != 3'd0) & ~w_byte_done;

    assign w_rx_next  = {r_rx_sr, w_mosi};
    assign w_cmd_addr = w_rx_next[ADDR_W-1:0];
    assign w_cmd_rw   = w_rx_next[7];
    assign w_addr_inc = r_addr + ADDR_W'(1);

    assign miso_o      = r_miso;
    assign miso_oeb_o  = ~w_active;
    assign busy_o      = w_active;
    assign reg_addr_o  = r_reg_addr;
    assign reg_wdata_o = r_reg_wdata;
    assign reg_we_o    = r_reg_we;
    assign reg_re_o    = r_reg_re;
    assign frame_err_o = r_frame_err;

    // Bring the SPI pins into the system clock domain; ssn resets low so a
    // frame needs a genuine high-to-low transition after reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sclk_sync <= '0;
            r_ssn_sync  <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ssn_prev  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_prev <= w_sclk;
            r_ssn_prev  <= w_ssn;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; SSn deassertion wins over everything else
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_ssn_fall) w_state_nxt = c_st_cmd;
            c_st_cmd:  if (w_byte_done) w_state_nxt = w_cmd_rw ? c_st_wr : c_st_rd;
            default:   w_state_nxt = r_state;
        endcase
        if (w_active && w_ssn_rise) begin
            w_state_nxt = c_st_idle;
        end
    end

    // Shift registers, address tracking, register-port strobes and MISO
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_bitcnt    <= 3'd0;
            r_rx_sr     <= 7'd0;
            r_tx_sr     <= 8'd0;
            r_addr      <= '0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
            // Read data is valid the cycle after the read strobe
            r_load_pend <= r_reg_re;

            if (!w_active) begin
                if (w_ssn_fall) begin
                    r_bitcnt <= 3'd0;
                    r_miso   <= 1'b0;
                end
            end else begin
                if (w_sclk_rise) begin
                    r_rx_sr  <= w_rx_next[6:0];
                    r_bitcnt <= r_bitcnt + 3'd1;
                end

                if ((r_state == c_st_rd) && w_sclk_fall && !r_load_pend) begin
                    r_miso  <= r_tx_sr[7];
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                end

                if (w_byte_done) begin
                    case (r_state)
                        c_st_cmd: begin
                            r_addr <= w_cmd_addr;
                            if (!w_cmd_rw) begin
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= w_cmd_addr;
                            end
                        end
                        c_st_rd: begin
                            // Prefetch the next byte of the burst
                            r_addr     <= w_addr_inc;
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= w_addr_inc;
                        end
                        default: begin
                            r_reg_we    <= 1'b1;
                            r_reg_wdata <= w_rx_next;
                            r_reg_addr  <= r_addr;
                            r_addr      <= w_addr_inc;
                        end
                    endcase
                end

                if (w_ssn_rise) begin
                    r_bitcnt    <= 3'd0;
                    r_miso      <= 1'b0;
                    r_frame_err <= w_abort;
                end
            end

            if (r_load_pend) begin
                r_tx_sr <= reg_rdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_regbridge.md
Name: spi_slave_regbridge

Overview:
SPI mode-0 target that terminates an SPI link from a master such as the SoC's SPI0/SPI1 (MSI/MSO/SSn/SCLK) and bridges each frame onto a simple byte-wide register-access port. All SPI pins are oversampled and synchronised into wb_clk_i; no logic runs on SCLK. It is used to let an external or on-die SPI master read and write a user register bank, e.g. in user-area test harnesses.

Parameters:
ADDR_W, 7, register address width; 1..7; the upper command bits above ADDR_W are ignored.
SYNC_STAGES, 2, synchroniser depth for sclk_i/ssn_i/mosi_i; 2..3.

Ports:
wb_clk_i  input  1  system clock; SCLK must be at most wb_clk_i/8.
wb_rst_i  input  1  reset; synchronous, active-high.
sclk_i  input  1  SPI clock, idle low (CPOL=0, CPHA=0).
ssn_i  input  1  SPI select, active-low.
mosi_i  input  1  master-out data.
miso_o  output  1  slave-out data.
miso_oeb_o  output  1  pad output-enable, active-low; 0 while a frame is active.
reg_addr_o  output  ADDR_W  register address.
reg_wdata_o  output  8  write data.
reg_we_o  output  1  one-cycle write strobe.
reg_re_o  output  1  one-cycle read strobe.
reg_rdata_i  input  8  read data; must be valid the cycle after reg_re_o.
busy_o  output  1  high while a frame is active.
frame_err_o  output  1  one-cycle pulse when SSn deasserts mid-byte.

Behaviour:
- Reset values: miso_o=0, miso_oeb_o=1, reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, reg_re_o=0, busy_o=0, frame_err_o=0. The FSM resets to IDLE and the bit counter to 0.
- Synchronisers: the sclk and mosi flops reset to 0. The ssn flops also reset to 0, so a frame starts only on a high-to-low transition seen after reset; a master holding SSn low through reset is ignored until SSn goes high and then low.
- Edge detect: compare the last two synchronised samples to get sclk_rise, sclk_fall, ssn_fall and ssn_rise.
- Frame format, MSB first:
  - Byte 0 is {rw, addr}, with rw=1 meaning write.
  - Each following byte is one data byte.
  - The address auto-increments after every data byte and wraps modulo 2^ADDR_W.
- FSM states: IDLE, CMD, RD, WR.
- IDLE:
  - On ssn_fall: go to CMD, bitcnt=0, busy_o=1, miso_oeb_o=0, miso_o=0.
  - SCLK activity while SSn is high is ignored.
- CMD:
  - Each sclk_rise shifts mosi into rx_sr and increments bitcnt.
  - On the 8th rise: latch addr and rw, and set bitcnt=0.
  - If rw=0: go to RD, pulse reg_re_o with reg_addr_o=addr in the following cycle, and load tx_sr from reg_rdata_i one cycle after that.
  - If rw=1: go to WR.
  - miso_o is held at 0 throughout CMD.
- RD:
  - Each sclk_fall drives miso_o=tx_sr[7] and shifts tx_sr left. The first fall after a byte boundary therefore presents bit 7.
  - On the 8th sclk_rise: addr<=addr+1, then reg_re_o/load as in CMD to prefetch the next byte.
  - The prefetch completes in 3 cycles, well inside the SCLK half-period of at least 4 cycles.
  - mosi bits are shifted but discarded.
- WR:
  - sclk_rise shifts mosi into rx_sr.
  - On the 8th rise: next cycle, reg_wdata_o=rx_sr, reg_addr_o=addr, reg_we_o=1 for exactly one cycle. The cycle after that, addr<=addr+1.
  - miso_o stays 0.
- reg_addr_o and reg_wdata_o hold their values between strobes.
- ssn_rise:
  - From any non-IDLE state, go to IDLE, miso_oeb_o=1, busy_o=0.
  - If bitcnt!=0, pulse frame_err_o and suppress the partial byte: no reg_we_o, no reg_re_o.
  - If ssn_rise coincides with the 8th-bit sclk_rise, the byte counts as complete and its strobe still fires.
- If wb_rst_i is asserted mid-frame: immediate return to reset values. No strobe is issued for any in-flight byte.
- Write-only frame of 1 byte (command only): no strobes. Read frame: one reg_re_o per data byte plus one prefetch for the byte after the last; the extra read is permitted.

Test Plan:
- Write frame 0x85,0xA5,0x3C (ADDR_W=7) -> reg_we_o at addr 0x05 data 0xA5, then addr 0x06 data 0x3C; exactly 2 strobes, no frame_err_o.
- Read frame 0x10, then 2 dummy bytes, with reg_rdata_i = addr XOR 0x55 -> MISO returns 0x45 then 0x44 MSB-first; reg_re_o fires at 0x10, 0x11 and 0x12.
- Write at addr 0x7F with 2 data bytes -> second strobe at addr 0x00 (wrap).
- SSn raised after 5 bits of a data byte in a write frame -> frame_err_o pulses once, no reg_we_o for that byte, miso_oeb_o=1 and busy_o=0 within SYNC_STAGES+2 cycles.
- Hold SSn low, pulse wb_rst_i mid-byte -> all outputs at reset values, SCLK ignored; transactions resume only after SSn goes high then low, and the next frame then works.
- SCLK toggled with SSn high, then SCLK at exactly wb_clk_i/8 -> no strobes while SSn is high; correct data at the maximum rate.
